mul3_fxp_pipe: RTL and testbench
================================

Name: mul3_fxp_pipe

Overview:
- Pipelined signed three-operand fixed-point multiplier with valid/ready streaming interfaces.
- Computes (a*b*c)/SCALE at full 3W-bit precision, then rounds and saturates back to W bits.
- Used by the 3D-to-2D transform datapath for rotation/projection products where each operand carries a decimal scale of SCALE.
- Generalises the earlier combinational triple multiplier in four ways: configurable width and scale, explicit signed arithmetic, selectable rounding, and saturation with an overflow flag.

Parameters:
- W, 16, operand and result width (two's-complement signed), 8..32.
- SCALE, 10000, positive integer divisor applied to the full product, 1..2^(W-1).
- ROUND, 0, rounding mode: 0 = truncate toward zero; 1 = round half away from zero.
- SAT, 1, overflow handling: 1 = saturate to the signed W-bit range; 0 = wrap (keep low W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand triple is valid.
- in_ready  out  1  block accepts the triple this cycle.
- in_a  in  W  signed operand a.
- in_b  in  W  signed operand b.
- in_c  in  W  signed operand c.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_q  out  W  signed result.
- out_ovf  out  1  result exceeded the W-bit range (saturated, or wrapped when SAT=0).

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): all stage valid bits=0, out_valid=0, out_q=0, out_ovf=0, all data registers=0. in_ready=1 after reset.
- Three register stages; all operands are treated as signed.
  - S1 registers p1 = a*b (2W bits) and c.
  - S2 registers p2 = p1*c (3W bits, exact, no truncation).
  - S3 registers the scaled, rounded, saturated result, which drives out_q and out_ovf.
- Latency: 3 cycles from input acceptance to out_valid with no stall. Throughput: 1 result per cycle.
- Pipeline advance: adv = !out_valid | out_ready. in_ready = adv (combinational). When adv=0, every stage holds its data and valid bit.
- Acceptance: a transfer happens on in_valid & in_ready; out consumption happens on out_valid & out_ready. Bubbles propagate as valid=0 and do not block advance.
- Scaling with ROUND=0: q = p2/SCALE, truncated toward zero. With ROUND=1: q = (|p2| + SCALE/2)/SCALE, then the sign of p2 is restored. The rounding intermediate must be 3W+1 bits so it cannot overflow.
- Range: if q > 2^(W-1)-1 or q < -2^(W-1), then out_ovf=1 and out_q saturates to the limit (SAT=1) or takes q[W-1:0] (SAT=0). Otherwise out_ovf=0.
- SCALE=1 bypasses rounding; the result is exact p2 with range handling applied.
- Simultaneous consume and accept in the same cycle: allowed; no bubble is inserted.
- out_q/out_ovf remain stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all in-flight results are discarded and no partial output is produced.
- in_a/in_b/in_c are don't-care when in_valid=0; the bench drives X to check that they do not propagate into valid results.

Test Plan:
- Defaults, a=-9306, b=99, c=99, out_ready=1 -> out_q=-9120 and ovf=0 exactly 3 cycles after acceptance. With ROUND=1 -> out_q=-9121.
- ROUND=1 tie cases:
  - (5000,1,1) -> 1; (-5000,1,1) -> -1.
  - With ROUND=0, both tie cases -> 0.
  - (4999,1,1) -> 0 in both modes.
- Saturation:
  - (32767,32767,32767) -> out_q=32767, ovf=1.
  - (-32768,-32768,-32768) -> out_q=-32768, ovf=1.
  - (100,100,100) -> 100, ovf=0.
- Back-pressure:
  - Stream 8 triples (i, 100, 100) for i=1..8 back-to-back. Hold out_ready=0 for 5 cycles from the first out_valid.
  - Required: in_ready=0 during the hold; out_q=1 held stable; then results 1..8 in order, with none lost or duplicated.
- Full throughput with random in_valid/out_ready (10k vectors, W=16 and W=12): results match the reference model for all ROUND/SAT combinations and ordering is preserved.
- Assert rst_n low while 3 results are in flight -> out_valid=0 and out_q=0 immediately. After release, the next single input yields exactly one result, 3 cycles after acceptance.

Source files
------------

// File: rtl/mul3_fxp_pipe.sv
// Three-stage pipelined signed fixed-point triple multiplier: (a*b*c)/SCALE,
// rounded and range-limited back to W bits, with valid/ready flow control.
module mul3_fxp_pipe #(
  parameter int W     = 16,
  parameter int SCALE = 10000,
  parameter int ROUND = 0,
  parameter int SAT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic         out_ovf
);

  localparam int PW = 3 * W;
  localparam int RW = PW + 1;

  localparam logic [RW-1:0]        SCALE_V = RW'(SCALE);
  localparam logic [RW-1:0]        HALF_V  = RW'(SCALE / 2);
  localparam logic signed [RW-1:0] Q_MAX   = {{(2*W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] Q_MIN   = {{(2*W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic            v1_q, v2_q, v3_q;
  logic [2*W-1:0]  p1_q, p1_d;
  logic [W-1:0]    c1_q;
  logic [PW-1:0]   p2_q, p2_d;
  logic [W-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            adv;

  logic                 neg;
  logic [RW-1:0]        p2_x, mag, qmag;
  logic signed [RW-1:0] q_s;

  // A stalled output freezes the whole pipe; bubbles never block advance.
  assign adv      = !v3_q | out_ready;
  assign in_ready = adv;

  // Sign-extending both factors to the product width makes a plain modular
  // multiply produce the exact two's-complement product.
  assign p1_d = {{W{in_a[W-1]}}, in_a} * {{W{in_b[W-1]}}, in_b};
  assign p2_d = {{W{p1_q[2*W-1]}}, p1_q} * {{(2*W){c1_q[W-1]}}, c1_q};

  always_comb begin
    neg  = p2_q[PW-1];
    p2_x = {p2_q[PW-1], p2_q};
    mag  = neg ? (RW'(0) - p2_x) : p2_x;
    // Working on the magnitude gives truncation toward zero and symmetric
    // half-away-from-zero rounding; the extra bit keeps mag + HALF_V exact.
    if (ROUND != 0) qmag = (mag + HALF_V) / SCALE_V;
    else            qmag = mag / SCALE_V;
    q_s   = neg ? (RW'(0) - qmag) : qmag;
    ovf_d = (q_s > Q_MAX) || (q_s < Q_MIN);
    res_d = q_s[W-1:0];
    if (ovf_d && (SAT != 0)) res_d = (q_s > Q_MAX) ? SAT_MAX : SAT_MIN;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, so out_q reads 0 after reset
      // rather than stale data from an aborted operation.
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      p1_q  <= '0;
      c1_q  <= '0;
      p2_q  <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // Data only loads behind a valid bit, so don't-care inputs never reach
      // the output registers.
      if (in_valid) begin
        p1_q <= p1_d;
        c1_q <= in_c;
      end
      if (v1_q) p2_q <= p2_d;
      if (v2_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_q     = res_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul3_fxp_pipe.sv
// Scoreboard bench for mul3_fxp_pipe: six parameter variants share one input
// stream; an arithmetic reference model predicts every result.
module tb_mul3_fxp_pipe;

  localparam int NI = 6;

  function automatic int cfg_w(int g);     return (g < 4) ? 16 : 12;      endfunction
  function automatic int cfg_scale(int g); return (g < 4) ? 10000 : 100;  endfunction
  function automatic int cfg_round(int g); return g % 2;                  endfunction
  function automatic int cfg_sat(int g);   return (g < 2 || g == 4) ? 1 : 0; endfunction

  typedef struct packed {
    logic signed [15:0] q;
    logic               ovf;
  } res_t;
  typedef res_t [NI-1:0] exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              out_ready;
  logic [15:0]       a_drv, b_drv, c_drv;
  logic [NI-1:0]     rdy, ov, ovf;
  logic signed [15:0] q_bus [NI];

  exp_t   exp_q[$];
  longint obs_q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_pop = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = cfg_w(g);
    logic signed [GW-1:0] q_loc;
    mul3_fxp_pipe #(
      .W(GW), .SCALE(cfg_scale(g)), .ROUND(cfg_round(g)), .SAT(cfg_sat(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy[g]),
      .in_a(a_drv[GW-1:0]), .in_b(b_drv[GW-1:0]), .in_c(c_drv[GW-1:0]),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_q(q_loc), .out_ovf(ovf[g])
    );
    assign q_bus[g] = 16'(q_loc);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reinterpret the low w bits of v as a signed w-bit number.
  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r -= m;
    return r;
  endfunction

  function automatic void model(input int g, input logic [15:0] a, b, c,
                                output longint q, output bit o);
    int     w;
    longint s, p, m, hi, lo;
    w  = cfg_w(g);
    s  = cfg_scale(g);
    p  = wrap(longint'($signed(a)), w) * wrap(longint'($signed(b)), w)
       * wrap(longint'($signed(c)), w);
    if (cfg_round(g) != 0) begin
      m = (p < 0) ? -p : p;
      m = (m + s / 2) / s;
      q = (p < 0) ? -m : m;
    end else begin
      q = p / s;
    end
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    o  = (q > hi) || (q < lo);
    if (o) q = (cfg_sat(g) != 0) ? ((q > hi) ? hi : lo) : wrap(q, w);
  endfunction

  // Monitor: pop and compare on every output transfer, push on every accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (|ov) check("valid_agree", ov, {NI{1'b1}});
      if (ov[0] && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          for (int g = 0; g < NI; g++) begin
            check($sformatf("res_q%0d", g), q_bus[g], $signed(e[g].q));
            check($sformatf("res_ovf%0d", g), ovf[g], e[g].ovf);
          end
        end
        obs_q.push_back(longint'(q_bus[0]));
        n_pop++;
      end
      if (in_valid && rdy[0]) begin
        exp_t   e;
        longint q;
        bit     o;
        for (int g = 0; g < NI; g++) begin
          model(g, a_drv, b_drv, c_drv, q, o);
          e[g].q   = 16'(q);
          e[g].ovf = o;
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    a_drv = 'x;
    b_drv = 'x;
    c_drv = 'x;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ov == '0) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  // One isolated transaction with out_ready held high; checks latency and the
  // variant-0 (truncate) and variant-1 (round) results against literals.
  task automatic run_single(input string name, input int a, b, c,
                            input int e0, input bit o0, input int e1, input bit o1);
    longint t0;
    bit     got;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_drv = 16'(a);
    b_drv = 16'(b);
    c_drv = 16'(c);
    @(negedge clk);
    check({name, "_accept"}, rdy[0], 1);
    t0 = cyc;
    @(posedge clk); #1;
    idle_inputs();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ov[0]) got = 1'b1;
    end
    check({name, "_latency"}, got ? (cyc - t0) : -1, 3);
    if (got) begin
      check({name, "_trunc_q"}, q_bus[0], e0);
      check({name, "_trunc_ovf"}, ovf[0], o0);
      check({name, "_round_q"}, q_bus[1], e1);
      check({name, "_round_ovf"}, ovf[1], o1);
    end
  endtask

  function automatic logic [15:0] pick();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 65535));
      3: case ($urandom_range(0, 3))
           0: v = -32768;
           1: v = 32767;
           2: v = 0;
           default: v = -1;
         endcase
      default: v = int'($urandom_range(0, 400)) - 200;
    endcase
    return 16'(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    #12;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset_valid%0d", g), ov[g], 0);
      check($sformatf("reset_q%0d", g), q_bus[g], 0);
      check($sformatf("reset_ovf%0d", g), ovf[g], 0);
      check($sformatf("reset_ready%0d", g), rdy[g], 1);
    end
    rst_n = 1'b1;

    run_single("basic",   -9306,    99,    99,  -9120, 0,  -9121, 0);
    run_single("tie_pos",  5000,     1,     1,      0, 0,      1, 0);
    run_single("tie_neg", -5000,     1,     1,      0, 0,     -1, 0);
    run_single("below",    4999,     1,     1,      0, 0,      0, 0);
    run_single("sat_pos", 32767, 32767, 32767,  32767, 1,  32767, 1);
    run_single("sat_neg", -32768, -32768, -32768, -32768, 1, -32768, 1);
    run_single("inrange",   100,   100,   100,    100, 0,    100, 0);
    wait_drain("directed_drain");

    // Back-pressure: 8 back-to-back triples, output stalled 5 cycles.
    begin
      int  idx  = 0;
      int  hold = 0;
      bit  seen = 1'b0;
      bit  acc  = 1'b0;
      obs_q.delete();
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (acc) idx++;
        if (idx < 8) begin
          in_valid = 1'b1;
          a_drv = 16'(idx + 1);
          b_drv = 16'd100;
          c_drv = 16'd100;
        end else begin
          idle_inputs();
        end
        if (!seen && ov[0]) begin
          seen = 1'b1;
          hold = 5;
        end
        out_ready = (hold == 0);
        @(negedge clk);
        acc = in_valid && rdy[0];
        if (hold > 0) begin
          check("bp_in_ready", rdy[0], 0);
          check("bp_hold_valid", ov[0], 1);
          check("bp_hold_q", q_bus[0], 1);
          hold--;
        end
      end
      @(posedge clk); #1;
      idle_inputs();
      out_ready = 1'b1;
      wait_drain("bp_drain");
      check("bp_count", obs_q.size(), 8);
      if (obs_q.size() == 8)
        for (int i = 0; i < 8; i++) check($sformatf("bp_order%0d", i), obs_q[i], i + 1);
    end

    // Random traffic on both handshakes.
    begin
      int cnt = 0;
      bit acc = 1'b0;
      for (int it = 0; it < 40000 && cnt < 10000; it++) begin
        @(posedge clk); #1;
        if (!in_valid || acc) begin
          if ($urandom_range(0, 99) < 70) begin
            in_valid = 1'b1;
            a_drv = pick();
            b_drv = pick();
            c_drv = pick();
          end else begin
            idle_inputs();
          end
        end
        out_ready = ($urandom_range(0, 99) < 75);
        @(negedge clk);
        acc = in_valid && rdy[0];
        if (acc) cnt++;
      end
      @(posedge clk); #1;
      idle_inputs();
      out_ready = 1'b1;
      wait_drain("rand_drain");
      check("rand_count", cnt, 10000);
    end

    // Reset with three results in flight.
    begin
      int n0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        a_drv = 16'(1000 * (k + 1));
        b_drv = 16'd100;
        c_drv = 16'd100;
      end
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < NI; g++) begin
        check($sformatf("midrst_valid%0d", g), ov[g], 0);
        check($sformatf("midrst_q%0d", g), q_bus[g], 0);
        check($sformatf("midrst_ovf%0d", g), ovf[g], 0);
      end
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      n0 = n_pop;
      run_single("post_rst", 123, 100, 100, 123, 0, 123, 0);
      repeat (6) @(negedge clk);
      check("post_rst_one_result", n_pop - n0, 1);
      check("post_rst_sb_empty", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
